// File: rtl/res_sta_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : res_sta_multi_if
// Purpose  : Dispatch, broadcast and issue bundle of the reservation station.
// Revision : 1.0 - initial release
// ============================================================================
interface res_sta_multi_if #(
    parameter int DEPTH       = 16,
    parameter int PARAM_COUNT = 3,
    parameter int DATA_W      = 16,
    parameter int UID_W       = 4,
    parameter int NUM_BCAST   = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                          in_valid;
    logic                          in_ready;
    logic [UID_W-1:0]              in_uid;
    logic [PARAM_COUNT*DATA_W-1:0] in_params;
    logic [PARAM_COUNT-1:0]        in_pending;
    logic [PARAM_COUNT*UID_W-1:0]  in_tags;
    logic [NUM_BCAST-1:0]          bc_valid;
    logic [NUM_BCAST*UID_W-1:0]    bc_uid;
    logic [NUM_BCAST*DATA_W-1:0]   bc_val;
    logic                          flush;
    logic                          out_valid;
    logic                          out_ready;
    logic [UID_W-1:0]              out_uid;
    logic [PARAM_COUNT*DATA_W-1:0] out_params;
    logic [CNT_W-1:0]              count;

    modport master (
        output in_valid, in_uid, in_params, in_pending, in_tags,
        output bc_valid, bc_uid, bc_val, flush, out_ready,
        input  in_ready, out_valid, out_uid, out_params, count
    );

    modport slave (
        input  in_valid, in_uid, in_params, in_pending, in_tags,
        input  bc_valid, bc_uid, bc_val, flush, out_ready,
        output in_ready, out_valid, out_uid, out_params, count
    );
endinterface
`default_nettype wire

// File: rtl/res_sta_multi.sv
`default_nettype none
// ============================================================================
// Module   : res_sta_multi
// Purpose  : Age-ordered reservation station with multi-port wakeup and a
//            registered issue stage.
// Revision : 1.0 - initial release
// ============================================================================
module res_sta_multi #(
    parameter int DEPTH       = 16,
    parameter int PARAM_COUNT = 3,
    parameter int DATA_W      = 16,
    parameter int UID_W       = 4,
    parameter int NUM_BCAST   = 2
) (
    input  wire logic      clk,
    input  wire logic      rst,
    res_sta_multi_if.slave bus
);
    localparam int              CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);
    localparam int              PW      = PARAM_COUNT * DATA_W;
    localparam int              TW      = PARAM_COUNT * UID_W;

    logic [DEPTH-1:0]       r_valid;
    logic [UID_W-1:0]       r_uid  [DEPTH];
    logic [PARAM_COUNT-1:0] r_pend [DEPTH];
    logic [TW-1:0]          r_tag  [DEPTH];
    logic [PW-1:0]          r_val  [DEPTH];
    logic [CNT_W-1:0]       r_count;
    logic                   r_out_valid;
    logic [UID_W-1:0]       r_out_uid;
    logic [PW-1:0]          r_out_params;

    logic                   w_in_ready;
    logic                   w_free;
    logic                   w_accept;
    logic                   w_sel_found;
    logic [CNT_W-1:0]       w_sel_idx;
    logic [UID_W-1:0]       w_sel_uid;
    logic [PW-1:0]          w_sel_params;
    logic                   w_issue;
    logic                   w_bypass;
    logic                   w_insert;
    logic [CNT_W-1:0]       w_ins_pos;
    logic [CNT_W-1:0]       w_n_count;
    logic [PARAM_COUNT-1:0] w_in_pend;
    logic [PW-1:0]          w_in_val;

    // Woken copies carry one extra always-empty slot so the shift never reads out of range.
    logic [DEPTH:0]         w_wk_valid;
    logic [UID_W-1:0]       w_wk_uid  [DEPTH+1];
    logic [PARAM_COUNT-1:0] w_wk_pend [DEPTH+1];
    logic [TW-1:0]          w_wk_tag  [DEPTH+1];
    logic [PW-1:0]          w_wk_val  [DEPTH+1];

    logic [DEPTH-1:0]       w_n_valid;
    logic [UID_W-1:0]       w_n_uid  [DEPTH];
    logic [PARAM_COUNT-1:0] w_n_pend [DEPTH];
    logic [TW-1:0]          w_n_tag  [DEPTH];
    logic [PW-1:0]          w_n_val  [DEPTH];

    // Returns {still_pending, value}; lowest matching port wins.
    function automatic logic [DATA_W:0] f_wake(
        input logic                        pend,
        input logic [UID_W-1:0]            tag,
        input logic [DATA_W-1:0]           val,
        input logic [NUM_BCAST-1:0]        bv,
        input logic [NUM_BCAST*UID_W-1:0]  bu,
        input logic [NUM_BCAST*DATA_W-1:0] bd
    );
        logic              hit;
        logic [DATA_W-1:0] v;
        hit = 1'b0;
        v   = val;
        if (pend) begin
            for (int b = 0; b < NUM_BCAST; b++) begin
                if (!hit && bv[b] && (bu[b*UID_W +: UID_W] == tag)) begin
                    hit = 1'b1;
                    v   = bd[b*DATA_W +: DATA_W];
                end
            end
        end
        return {pend & ~hit, v};
    endfunction

    assign w_in_ready = (r_count < c_DEPTH);

    always_comb begin
        w_free   = !r_out_valid || bus.out_ready;
        w_accept = bus.in_valid && w_in_ready;

        w_sel_found  = 1'b0;
        w_sel_idx    = '0;
        w_sel_uid    = '0;
        w_sel_params = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_sel_found && r_valid[i] && (r_pend[i] == '0)) begin
                w_sel_found  = 1'b1;
                w_sel_idx    = CNT_W'(i);
                w_sel_uid    = r_uid[i];
                w_sel_params = r_val[i];
            end
        end

        w_issue   = w_free && w_sel_found;
        w_bypass  = w_free && !w_sel_found && w_accept && (bus.in_pending == '0);
        w_insert  = w_accept && !w_bypass;
        w_ins_pos = w_issue ? (r_count - c_ONE) : r_count;

        w_n_count = r_count;
        if (w_insert && !w_issue) begin
            w_n_count = r_count + c_ONE;
        end else if (!w_insert && w_issue) begin
            w_n_count = r_count - c_ONE;
        end

        w_in_pend = '0;
        w_in_val  = '0;
        for (int p = 0; p < PARAM_COUNT; p++) begin
            {w_in_pend[p], w_in_val[p*DATA_W +: DATA_W]} = f_wake(
                bus.in_pending[p], bus.in_tags[p*UID_W +: UID_W],
                bus.in_params[p*DATA_W +: DATA_W],
                bus.bc_valid, bus.bc_uid, bus.bc_val);
        end

        w_wk_valid        = '0;
        w_wk_uid[DEPTH]   = '0;
        w_wk_pend[DEPTH]  = '0;
        w_wk_tag[DEPTH]   = '0;
        w_wk_val[DEPTH]   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wk_valid[i] = r_valid[i];
            w_wk_uid[i]   = r_uid[i];
            w_wk_tag[i]   = r_tag[i];
            w_wk_pend[i]  = '0;
            w_wk_val[i]   = '0;
            for (int p = 0; p < PARAM_COUNT; p++) begin
                {w_wk_pend[i][p], w_wk_val[i][p*DATA_W +: DATA_W]} = f_wake(
                    r_valid[i] & r_pend[i][p], r_tag[i][p*UID_W +: UID_W],
                    r_val[i][p*DATA_W +: DATA_W],
                    bus.bc_valid, bus.bc_uid, bus.bc_val);
            end
        end

        // Compact over the issued slot, then append the new entry at the tail.
        for (int i = 0; i < DEPTH; i++) begin
            if (w_issue && (CNT_W'(i) >= w_sel_idx)) begin
                w_n_valid[i] = w_wk_valid[i+1];
                w_n_uid[i]   = w_wk_uid[i+1];
                w_n_pend[i]  = w_wk_pend[i+1];
                w_n_tag[i]   = w_wk_tag[i+1];
                w_n_val[i]   = w_wk_val[i+1];
            end else begin
                w_n_valid[i] = w_wk_valid[i];
                w_n_uid[i]   = w_wk_uid[i];
                w_n_pend[i]  = w_wk_pend[i];
                w_n_tag[i]   = w_wk_tag[i];
                w_n_val[i]   = w_wk_val[i];
            end
            if (w_insert && (CNT_W'(i) == w_ins_pos)) begin
                w_n_valid[i] = 1'b1;
                w_n_uid[i]   = bus.in_uid;
                w_n_pend[i]  = w_in_pend;
                w_n_tag[i]   = bus.in_tags;
                w_n_val[i]   = w_in_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= '0;
            r_count      <= '0;
            r_out_valid  <= 1'b0;
            r_out_uid    <= '0;
            r_out_params <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_uid[i]  <= '0;
                r_pend[i] <= '0;
                r_tag[i]  <= '0;
                r_val[i]  <= '0;
            end
        end else if (bus.flush) begin
            r_valid     <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_valid <= w_n_valid;
            r_count <= w_n_count;
            for (int i = 0; i < DEPTH; i++) begin
                r_uid[i]  <= w_n_uid[i];
                r_pend[i] <= w_n_pend[i];
                r_tag[i]  <= w_n_tag[i];
                r_val[i]  <= w_n_val[i];
            end
            if (w_free) begin
                if (w_issue) begin
                    r_out_valid  <= 1'b1;
                    r_out_uid    <= w_sel_uid;
                    r_out_params <= w_sel_params;
                end else if (w_bypass) begin
                    r_out_valid  <= 1'b1;
                    r_out_uid    <= bus.in_uid;
                    r_out_params <= bus.in_params;
                end else begin
                    r_out_valid  <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_uid    = r_out_uid;
    assign bus.out_params = r_out_params;
    assign bus.count      = r_count;
endmodule
`default_nettype wire

// File: tb/tb_res_sta_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_res_sta_multi
// Purpose  : Directed vector table plus hand sequences for res_sta_multi.
// Revision : 1.0 - initial release
// ============================================================================
module tb_res_sta_multi;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    res_sta_multi_if #(.DEPTH(16), .PARAM_COUNT(3), .DATA_W(16), .UID_W(4), .NUM_BCAST(2)) bus ();

    res_sta_multi #(.DEPTH(16), .PARAM_COUNT(3), .DATA_W(16), .UID_W(4), .NUM_BCAST(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        in_valid;
        logic [3:0]  uid;
        logic [47:0] params;
        logic [2:0]  pend;
        logic [11:0] tags;
        logic [1:0]  bcv;
        logic [7:0]  bcu;
        logic [31:0] bcd;
        logic        out_ready;
        logic        e_ov;
        logic [3:0]  e_uid;
        logic [47:0] e_params;
        logic [4:0]  e_cnt;
        logic        e_rdy;
    } vec_t;

    function automatic logic [47:0] P3(input int a, input int b, input int c);
        return {c[15:0], b[15:0], a[15:0]};
    endfunction
    function automatic logic [11:0] T3(input int a, input int b, input int c);
        return {c[3:0], b[3:0], a[3:0]};
    endfunction
    function automatic logic [7:0] BU(input int a, input int b);
        return {b[3:0], a[3:0]};
    endfunction
    function automatic logic [31:0] BD(input int a, input int b);
        return {b[15:0], a[15:0]};
    endfunction

    function automatic vec_t mkv(input int iv, input int u, input logic [47:0] pr, input int pd,
                                 input logic [11:0] tg, input int bv, input logic [7:0] bu,
                                 input logic [31:0] bd, input int ordy, input int eov, input int eu,
                                 input logic [47:0] ep, input int ec, input int er);
        vec_t v;
        v.in_valid = iv[0];   v.uid = u[3:0];    v.params = pr;     v.pend = pd[2:0];
        v.tags = tg;          v.bcv = bv[1:0];   v.bcu = bu;        v.bcd = bd;
        v.out_ready = ordy[0]; v.e_ov = eov[0];  v.e_uid = eu[3:0]; v.e_params = ep;
        v.e_cnt = ec[4:0];    v.e_rdy = er[0];
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.in_valid   = v.in_valid;
        bus.in_uid     = v.uid;
        bus.in_params  = v.params;
        bus.in_pending = v.pend;
        bus.in_tags    = v.tags;
        bus.bc_valid   = v.bcv;
        bus.bc_uid     = v.bcu;
        bus.bc_val     = v.bcd;
        bus.out_ready  = v.out_ready;
    endtask

    task automatic dispatch(input int u, input logic [47:0] pr, input int pd, input logic [11:0] tg);
        bus.in_valid   = 1'b1;
        bus.in_uid     = u[3:0];
        bus.in_params  = pr;
        bus.in_pending = pd[2:0];
        bus.in_tags    = tg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic e_ov, input logic [3:0] e_uid,
                         input logic [47:0] e_params, input logic [4:0] e_cnt,
                         input logic e_rdy, input logic chk_pl);
        logic ok;
        n_vec++;
        ok = (bus.out_valid === e_ov) && (bus.count === e_cnt) && (bus.in_ready === e_rdy) &&
             (!chk_pl || ((bus.out_uid === e_uid) && (bus.out_params === e_params)));
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got ov=%0b uid=%0d params=%h count=%0d rdy=%0b, expected ov=%0b uid=%0d params=%h count=%0d rdy=%0b",
                     name, bus.out_valid, bus.out_uid, bus.out_params, bus.count, bus.in_ready,
                     e_ov, e_uid, e_params, e_cnt, e_rdy);
        end
    endtask

    vec_t vt [14];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        bus.in_valid = 1'b0; bus.in_uid = '0; bus.in_params = '0; bus.in_pending = '0;
        bus.in_tags = '0; bus.bc_valid = '0; bus.bc_uid = '0; bus.bc_val = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;

        vt[0]  = mkv(1, 3, P3(5,6,7), 0, T3(0,0,0), 0, BU(0,0), BD(0,0), 1,  1, 3, P3(5,6,7), 0, 1);
        vt[1]  = mkv(0, 0, P3(0,0,0), 0, T3(0,0,0), 0, BU(0,0), BD(0,0), 1,  0, 0, P3(0,0,0), 0, 1);
        vt[2]  = mkv(1, 4, P3(1,0,3), 3'b010, T3(0,2,0), 0, BU(0,0), BD(0,0), 1,  0, 0, P3(0,0,0), 1, 1);
        vt[3]  = mkv(0, 0, P3(0,0,0), 0, T3(0,0,0), 0, BU(0,0), BD(0,0), 1,  0, 0, P3(0,0,0), 1, 1);
        vt[4]  = mkv(0, 0, P3(0,0,0), 0, T3(0,0,0), 2'b10, BU(0,2), BD(0,16'h1234), 1,  0, 0, P3(0,0,0), 1, 1);
        vt[5]  = mkv(0, 0, P3(0,0,0), 0, T3(0,0,0), 0, BU(0,0), BD(0,0), 1,  1, 4, P3(1,16'h1234,3), 0, 1);
        vt[6]  = mkv(1, 5, P3(0,8,8), 3'b001, T3(6,0,0), 2'b01, BU(6,0), BD(9,0), 1,  0, 0, P3(0,0,0), 1, 1);
        vt[7]  = mkv(0, 0, P3(0,0,0), 0, T3(0,0,0), 0, BU(0,0), BD(0,0), 1,  1, 5, P3(9,8,8), 0, 1);
        vt[8]  = mkv(1, 8, P3(2,2,0), 3'b100, T3(1,1,1), 0, BU(0,0), BD(0,0), 1,  0, 0, P3(0,0,0), 1, 1);
        vt[9]  = mkv(0, 0, P3(0,0,0), 0, T3(0,0,0), 2'b11, BU(1,1), BD(16'hAA,16'hBB), 1,  0, 0, P3(0,0,0), 1, 1);
        vt[10] = mkv(0, 0, P3(0,0,0), 0, T3(0,0,0), 0, BU(0,0), BD(0,0), 1,  1, 8, P3(2,2,16'hAA), 0, 1);
        vt[11] = mkv(1, 9, P3(1,2,3), 0, T3(0,0,0), 0, BU(0,0), BD(0,0), 0,  1, 8, P3(2,2,16'hAA), 1, 1);
        vt[12] = mkv(0, 0, P3(0,0,0), 0, T3(0,0,0), 0, BU(0,0), BD(0,0), 1,  1, 9, P3(1,2,3), 0, 1);
        vt[13] = mkv(0, 0, P3(0,0,0), 0, T3(0,0,0), 0, BU(0,0), BD(0,0), 1,  0, 0, P3(0,0,0), 0, 1);

        tick();
        check("reset", 1'b0, 4'd0, 48'd0, 5'd0, 1'b1, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vt[i]);
            tick();
            check($sformatf("vec%0d", i), vt[i].e_ov, vt[i].e_uid, vt[i].e_params,
                  vt[i].e_cnt, vt[i].e_rdy, vt[i].e_ov);
        end

        // Fill all 16 slots, each waiting on operand 0 with tag equal to its uid.
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            dispatch(k, P3(0, k, 16'h100 + k), 3'b001, T3(k, 0, 0));
            tick();
        end
        check("fill", 1'b0, 4'd0, 48'd0, 5'd16, 1'b0, 1'b0);
        dispatch(0, P3(0,0,0), 3'b001, T3(0,0,0));
        tick();
        check("full_drop", 1'b0, 4'd0, 48'd0, 5'd16, 1'b0, 1'b0);

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.bc_valid  = 2'b11;
        bus.bc_uid    = BU(7, 2);
        bus.bc_val    = BD(16'h77, 16'h22);
        tick();
        check("bc_resolve", 1'b0, 4'd0, 48'd0, 5'd16, 1'b0, 1'b0);
        bus.bc_valid = 2'b00;
        tick();
        check("issue_u2", 1'b1, 4'd2, P3(16'h22, 2, 16'h102), 5'd15, 1'b1, 1'b1);
        for (int h = 0; h < 3; h++) begin
            tick();
            check($sformatf("hold_u2_%0d", h), 1'b1, 4'd2, P3(16'h22, 2, 16'h102), 5'd15, 1'b1, 1'b1);
        end
        bus.out_ready = 1'b1;
        tick();
        check("issue_u7", 1'b1, 4'd7, P3(16'h77, 7, 16'h107), 5'd14, 1'b1, 1'b1);
        tick();
        check("drain", 1'b0, 4'd0, 48'd0, 5'd14, 1'b1, 1'b0);

        bus.flush = 1'b1;
        tick();
        check("flush_clear", 1'b0, 4'd0, 48'd0, 5'd0, 1'b1, 1'b0);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            dispatch(k, P3(0, k, k), 3'b001, T3(15, 0, 0));
            tick();
        end
        dispatch(10, P3(10, 10, 10), 0, T3(0,0,0));
        tick();
        check("bypass_u10", 1'b1, 4'd10, P3(10, 10, 10), 5'd5, 1'b1, 1'b1);
        dispatch(11, P3(11, 11, 11), 0, T3(0,0,0));
        bus.flush = 1'b1;
        tick();
        check("flush_drop", 1'b0, 4'd0, 48'd0, 5'd0, 1'b1, 1'b0);
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.bc_valid  = 2'b01;
        bus.bc_uid    = BU(15, 0);
        bus.bc_val    = BD(1, 0);
        for (int h = 0; h < 3; h++) begin
            tick();
            check($sformatf("post_flush_%0d", h), 1'b0, 4'd0, 48'd0, 5'd0, 1'b1, 1'b0);
        end

        bus.bc_valid  = 2'b00;
        bus.out_ready = 1'b0;
        dispatch(3, P3(3, 3, 3), 0, T3(0,0,0));
        tick();
        dispatch(4, P3(4, 4, 4), 3'b001, T3(15, 0, 0));
        tick();
        check("pre_rst", 1'b1, 4'd3, P3(3, 3, 3), 5'd1, 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #2;
        check("async_rst", 1'b0, 4'd0, 48'd0, 5'd0, 1'b1, 1'b1);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("after_rst", 1'b0, 4'd0, 48'd0, 5'd0, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/res_sta_multi.md
Name: res_sta_multi

Overview:
- Parametrised reservation station for one functional unit, sitting between rename/ROB dispatch and the FU.
- Holds up to DEPTH instructions in age order.
- Wakes pending operands from NUM_BCAST parallel result-broadcast ports.
- Issues the oldest fully-ready entry through a valid/ready output register, so a stalled FU never loses an issued instruction.

Parameters:
- DEPTH, 16, entry count (>=2).
- PARAM_COUNT, 3, operands per entry (>=1).
- DATA_W, 16, operand width.
- UID_W, 4, ROB uid/tag width.
- NUM_BCAST, 2, broadcast ports (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  dispatch request.
- in_ready  out  1  station can accept; registered-state based.
- in_uid  in  UID_W  ROB uid of dispatched instr.
- in_params  in  PARAM_COUNT*DATA_W  operand values; operand p at [p*DATA_W +: DATA_W].
- in_pending  in  PARAM_COUNT  1 = operand p awaits producer in_tags[p].
- in_tags  in  PARAM_COUNT*UID_W  producer uid per operand.
- bc_valid  in  NUM_BCAST  broadcast valid per port.
- bc_uid  in  NUM_BCAST*UID_W  finishing uid.
- bc_val  in  NUM_BCAST*DATA_W  finishing result.
- flush  in  1  synchronous squash of all contents.
- out_valid  out  1  issue register holds an instr.
- out_ready  in  1  FU accepts.
- out_uid  out  UID_W  issued uid.
- out_params  out  PARAM_COUNT*DATA_W  issued operands.
- count  out  $clog2(DEPTH+1)  occupied entries, excluding the output register.

Behaviour:
- Reset (async): all entries invalid; count=0; out_valid=0; out_uid=0; out_params=0; in_ready=1.
- Entry state: valid, uid, PARAM_COUNT x {pending, tag, value}. Slots are compacted: slot 0 oldest, slots [0,count) valid.
- Accept: in_valid & in_ready at edge.
- in_ready = (count < DEPTH). It is never combinationally dependent on out_ready or issue.
- Insert-time wakeup: for each pending operand, if any bc_valid[b] & bc_uid[b]==tag in the same cycle, the operand is stored resolved with bc_val[b].
- Wakeup: every edge, each valid entry's pending operand matching a valid broadcast takes bc_val, pending<=0.
  - Multiple ports matching the same tag: lowest port index wins.
  - Broadcasts never modify non-pending operands.
- Output register free this cycle: free = !out_valid | out_ready.
- Select: when free, pick the lowest-index valid entry whose pending bits are all 0 (registered state). Move it into the output register at the edge: out_valid<=1. Slots above it shift down by one.
- Bypass: when free, no stored entry is eligible, and the accepted instr has in_pending all 0, it loads directly into the output register. It never occupies a slot. Latency dispatch->out_valid = 1 cycle.
- Normal latency: entry resolved at edge N is selectable in cycle N, out_valid at edge N+1. Operands resolved by the same edge's broadcast become eligible the following cycle.
- If free and nothing to issue: out_valid<=0.
- If !free: output register holds uid/params stable; out_valid stays 1.
- Simultaneous insert + issue: new entry appended at slot count-1 after the shift (count unchanged). Insert-only: count+1. Issue-only: count-1.
- Operand values in the output register are never updated by broadcasts.
- flush: takes priority over insert/issue/wakeup. Next edge: all entries invalid, count=0, out_valid=0. Any in_valid that cycle is dropped.
- Reset asserted mid-operation: immediate clear as above; no partial state survives.
- uid width arithmetic: tags are compared as full UID_W; no wrap handling is needed (uids are unique while in flight).

Test Plan:
- Ready dispatch: in_pending=000, uid=3, params {5,6,7}, out_ready=1 -> out_valid=1 next cycle, out_uid=3, out_params={5,6,7}, count stays 0.
- Wakeup: dispatch uid=4 with operand1 pending on tag 2; later bc port1 uid=2 val=0x1234 -> entry issues next cycle with param1=0x1234.
- Same-cycle insert+broadcast: dispatch uid=5 pending on tag 6 while bc0 broadcasts uid=6 val=9 -> param resolves to 9; issues following cycle.
- Ordering/backpressure: fill uids 0..15 all pending, count=16, in_ready=0. Broadcast resolving uids 7 and 2 together, hold out_ready=0 for 3 cycles -> uid 2 issues first and is held stable for those 3 cycles; then uid 7 issues; count reaches 14.
- Dual-port conflict: bc0 and bc1 both uid=1, vals 0xAA/0xBB -> waiting operand gets 0xAA.
- Flush: 5 entries plus out_valid=1, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, dropped dispatch never issues.
